// File: rtl/fp_sign_pkg.sv
// rtl/fp_sign_pkg.sv - shared types, constants and field classifiers for fp_sign_unit
package fp_sign_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_ABS  = 2'd1,
    MODE_NEG  = 2'd2,
    MODE_NABS = 2'd3
  } mode_e;

  localparam logic [31:0] CANON_NAN32 = 32'h7FC0_0000;
  localparam logic [63:0] CANON_NAN64 = 64'h7FF8_0000_0000_0000;

  // value is the element zero-extended to 64 bits; fp_w gives its real width
  function automatic logic is_nan(input logic [63:0] value, input int unsigned exp_w,
                                  input int unsigned fp_w);
    logic [63:0] exp_mask;
    logic [63:0] man_mask;
    int unsigned man_w;
    man_w    = fp_w - 1 - exp_w;
    man_mask = (64'd1 << man_w) - 64'd1;
    exp_mask = ((64'd1 << exp_w) - 64'd1) << man_w;
    return ((value & exp_mask) == exp_mask) && ((value & man_mask) != 64'd0);
  endfunction

  function automatic logic is_zero(input logic [63:0] value, input int unsigned exp_w,
                                   input int unsigned fp_w);
    logic [63:0] mag_mask;
    mag_mask = (64'd1 << (fp_w - 1)) - 64'd1;
    return (exp_w != 0) && ((value & mag_mask) == 64'd0);
  endfunction

endpackage

// File: rtl/fp_sign_lane.sv
// rtl/fp_sign_lane.sv - one combinational sign-manipulation lane with NaN/zero flags
// FP_SIGN_NAN_CANON_EN: when defined, NaN lanes are replaced by the canonical quiet NaN.
module fp_sign_lane
  import fp_sign_pkg::*;
#(
  parameter int FP_W  = 32,
  parameter int EXP_W = 8
) (
  input  mode_e             mode_i,
  input  logic [FP_W-1:0]   data_i,
  output logic [FP_W-1:0]   data_o,
  output logic              nan_o,
  output logic              zero_o
);

  localparam logic [FP_W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FP_W-EXP_W-2){1'b0}}};

  logic [63:0] data_ext;
  logic        sign_d;

  assign data_ext = 64'(data_i);
  assign nan_o    = is_nan(data_ext, EXP_W, FP_W);
  assign zero_o   = is_zero(data_ext, EXP_W, FP_W);

  // Select the new sign bit from the mode; exponent and mantissa pass through
  always_comb begin
    sign_d = data_i[FP_W-1];
    case (mode_i)
      MODE_PASS: sign_d = data_i[FP_W-1];
      MODE_ABS:  sign_d = 1'b0;
      MODE_NEG:  sign_d = ~data_i[FP_W-1];
      MODE_NABS: sign_d = 1'b1;
      default:   sign_d = data_i[FP_W-1];
    endcase
  end

`ifdef FP_SIGN_NAN_CANON_EN
  assign data_o = nan_o ? CANON_NAN : {sign_d, data_i[FP_W-2:0]};
`else
  assign data_o = {sign_d, data_i[FP_W-2:0]};
`endif

endmodule

// File: rtl/fp_sign_unit.sv
// rtl/fp_sign_unit.sv - pipelined multi-lane IEEE-754 sign unit with handshake and NaN counter
// FP_SIGN_NAN_CANON_EN: forwarded to fp_sign_lane, canonicalises NaN lanes when defined.
module fp_sign_unit
  import fp_sign_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int FP_W   = 32,
  parameter int EXP_W  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    areset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_mode,
  input  logic [LANES*FP_W-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*FP_W-1:0]   out_data,
  output logic [LANES-1:0]        out_nan,
  output logic [LANES-1:0]        out_zero,
  output logic [CNT_W-1:0]        nan_count,
  input  logic                    clr_count
);

  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  mode_e                  mode;
  logic [LANES*FP_W-1:0]  lane_data;
  logic [LANES-1:0]       lane_nan;
  logic [LANES-1:0]       lane_zero;

  logic [LANES*FP_W-1:0]  data_q [STAGES];
  logic [LANES-1:0]       nan_q  [STAGES];
  logic [LANES-1:0]       zero_q [STAGES];
  logic [STAGES-1:0]      vld_q;
  logic [STAGES-1:0]      vld_d;

  logic [LANES*FP_W-1:0]  src_data [STAGES];
  logic [LANES-1:0]       src_nan  [STAGES];
  logic [LANES-1:0]       src_zero [STAGES];
  logic [STAGES-1:0]      src_vld;
  logic [STAGES-1:0]      load;

  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [PC_W-1:0]        pop;
  logic [SUM_W-1:0]       sum;

  assign mode = mode_e'(in_mode);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_sign_lane #(
      .FP_W  (FP_W),
      .EXP_W (EXP_W)
    ) u_lane (
      .mode_i (mode),
      .data_i (in_data[i*FP_W +: FP_W]),
      .data_o (lane_data[i*FP_W +: FP_W]),
      .nan_o  (lane_nan[i]),
      .zero_o (lane_zero[i])
    );
  end

  // Slot s loads when any slot at or after s is empty or the output drains
  always_comb begin
    load = '0;
    for (int s = 0; s < STAGES; s++) begin
      load[s] = out_ready | (|((~vld_q) >> s));
    end
  end

  // Source of each slot: slot 0 takes the computed lanes, others the previous slot
  always_comb begin
    src_data[0] = lane_data;
    src_nan[0]  = lane_nan;
    src_zero[0] = lane_zero;
    src_vld[0]  = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      src_data[s] = data_q[s-1];
      src_nan[s]  = nan_q[s-1];
      src_zero[s] = zero_q[s-1];
      src_vld[s]  = vld_q[s-1];
    end
    vld_d = vld_q;
    for (int s = 0; s < STAGES; s++) begin
      if (load[s]) vld_d[s] = src_vld[s];
    end
  end

  // Saturating NaN count; clear wins over a coincident output transfer
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + PC_W'(out_nan[i]);
    end
    sum   = SUM_W'(cnt_q) + SUM_W'(pop);
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = '0;
    end else if (out_valid && out_ready) begin
      cnt_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end
  end

  // Pipeline slots and counter; reset discards everything in flight
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
        nan_q[s]  <= '0;
        zero_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int s = 0; s < STAGES; s++) begin
        if (load[s] && src_vld[s]) begin
          data_q[s] <= src_data[s];
          nan_q[s]  <= src_nan[s];
          zero_q[s] <= src_zero[s];
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_nan   = nan_q[STAGES-1];
  assign out_zero  = zero_q[STAGES-1];
  assign nan_count = cnt_q;

endmodule
